instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly downstream of the program counter. Each cycle it samples the PC index, issues a read to program memory and advances the PC. It absorbs fixed memory read latency and delivers instructions to the decoder over a valid/ready handshake through a small FIFO. It also converts decoder jump requests into PC set commands, flushing all stale in-flight fetches.

## Interface
Parameters:
- MEM_LATENCY, 2: cycles from mem_rd to mem_rdata valid; legal range 1..4.
- DATA_W, 16: instruction width.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, at least MEM_LATENCY+1.
- LAST_ADDR, 16'hBFFF: top of program space; the PC saturates here.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; all state clears immediately on assertion.
- pc_index  in  16  current PC value.
- pc_enable  out  1  PC update strobe.
- pc_inc_or_set  out  1  0 = increment, 1 = load pc_new_value.
- pc_new_value  out  16  PC load value; equals redirect_addr.
- mem_rd  out  1  program memory read strobe.
- mem_addr  out  16  read address; equals pc_index when mem_rd=1.
- mem_rdata  in  DATA_W  read data, valid exactly MEM_LATENCY cycles after mem_rd.
- redirect  in  1  jump request from decoder; single-cycle pulse.
- redirect_addr  in  16  jump target.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decoder accepts head.
- instr_data  out  DATA_W  head instruction.
- instr_addr  out  16  address the head instruction was fetched from.

## Operation
- Issue condition: no redirect this cycle, done=0, and inflight + fifo_count < FIFO_DEPTH. A pop in the same cycle is not credited, which is conservative. When the condition holds: mem_rd=1, mem_addr=pc_index, pc_enable=1, pc_inc_or_set=0.
- In-flight tracking: an MEM_LATENCY-deep shift register of {valid, addr}. When a valid bit exits the register, {mem_rdata, addr} is pushed into the FIFO. The credit check guarantees the FIFO never overflows.
- Done flag: set when an issue occurs with pc_index==LAST_ADDR. While done=1, no further issues occur; this prevents refetching the saturated address. The flag clears only on redirect or reset.
- Redirect: pc_enable=1, pc_inc_or_set=1, pc_new_value=redirect_addr, mem_rd=0. On the same edge:
  - all shift-register valid bits clear;
  - the FIFO empties;
  - done clears.
- Redirect and a pop in the same cycle: the handshake completes and the instruction counts as consumed; all remaining entries are flushed.
- Handshake: a transfer occurs when instr_valid & instr_ready. instr_data and instr_addr hold stable while instr_valid=1 and instr_ready=0.
- Outputs are combinational from registered state plus redirect and pc_index. There is no combinational path from instr_ready to mem_rd.

## Timing
- Reset values: pc_enable=0, pc_inc_or_set=0, pc_new_value=0, mem_rd=0, mem_addr=0, instr_valid=0, instr_data=0, instr_addr=0, done=0, counters=0.
- First mem_rd occurs in the first cycle after reset deasserts.
- Fetch-to-valid latency: MEM_LATENCY+1 cycles (issue at cycle t; instr_valid at t+MEM_LATENCY+1).
- Throughput: one instruction per cycle while the decoder is always ready.
- After a redirect at cycle t, the first fetch of redirect_addr issues at t+1. The PC loads on the edge ending t.
- Reset mid-operation: in-flight reads are discarded. Memory responses arriving after reset are ignored because all valid bits are clear.

## Configuration
- IFETCH_STALL_COUNT_EN
  - Defined: adds output stall_count (16 bits, reset 0). It increments each cycle in which the issue condition fails for reasons other than done or redirect. It saturates at 16'hFFFF and clears only on reset.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, pc_index incrementing from 0, instr_ready=1: mem_rd every cycle. instr_valid rises 3 cycles after the first issue, with instr_addr 0, 1, 2… and matching data.
- Hold instr_ready=0: at most 4 issues occur, then mem_rd=0. After instr_ready is raised, four entries drain in order and issue resumes.
- Redirect to 16'h0100 while 2 reads are in flight and 2 are buffered:
  - one-cycle pc_enable=1, pc_inc_or_set=1, pc_new_value=16'h0100;
  - the stale responses never appear;
  - the next delivered instr_addr is 16'h0100.
- Start the PC at 16'hBFFE: exactly two issues occur (BFFE, BFFF), then mem_rd stays 0. A redirect to 0 resumes fetching.
- Assert reset mid-stream with reads in flight: all outputs go to 0 immediately, and no instr_valid appears from the old reads after release.
- With IFETCH_STALL_COUNT_EN, hold instr_ready=0 for 10 cycles after the FIFO fills: stall_count=10.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues program-memory reads, tracks fixed-latency responses
// and buffers them in a FIFO for the decoder. Optional IFETCH_STALL_COUNT_EN adds stall_count.
module instr_fetch #(
    parameter int          MEM_LATENCY = 2,
    parameter int          DATA_W      = 16,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] LAST_ADDR   = 16'hBFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       pc_index,
    output logic              pc_enable,
    output logic              pc_inc_or_set,
    output logic [15:0]       pc_new_value,
    output logic              mem_rd,
    output logic [15:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [15:0]       redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [15:0]       instr_addr
`ifdef IFETCH_STALL_COUNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [MEM_LATENCY-1:0]             vld_q, vld_d;
    logic [MEM_LATENCY-1:0][15:0]       pipe_addr_q, pipe_addr_d;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0]  fifo_data_q, fifo_data_d;
    logic [FIFO_DEPTH-1:0][15:0]        fifo_addr_q, fifo_addr_d;
    logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               done_q, done_d;

    logic       redir;
    logic       credit_ok;
    logic       issue;
    logic       push;
    logic       pop;
    logic [7:0] occ;

    // Outputs are forced low while reset is held, since the issue logic would otherwise
    // see an empty pipeline and strobe mem_rd.
    always_comb begin
        occ = 8'(cnt_q);
        for (int i = 0; i < MEM_LATENCY; i++) occ = occ + 8'(vld_q[i]);
        credit_ok = occ < 8'(FIFO_DEPTH);
        redir     = reset & redirect;
        issue     = reset & ~redirect & ~done_q & credit_ok;
        push      = vld_q[MEM_LATENCY-1] & ~redir;
        pop       = instr_valid & instr_ready;
    end

    assign mem_rd        = issue;
    assign mem_addr      = issue ? pc_index : 16'h0000;
    assign pc_enable     = issue | redir;
    assign pc_inc_or_set = redir;
    assign pc_new_value  = redir ? redirect_addr : 16'h0000;
    assign instr_valid   = cnt_q != '0;
    assign instr_data    = fifo_data_q[rd_ptr_q];
    assign instr_addr    = fifo_addr_q[rd_ptr_q];

    always_comb begin
        vld_d          = vld_q;
        pipe_addr_d    = pipe_addr_q;
        vld_d[0]       = issue;
        pipe_addr_d[0] = pc_index;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_d[i]       = vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end
        if (redir) vld_d = '0;
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_addr_d = fifo_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_addr_d[wr_ptr_q] = pipe_addr_q[MEM_LATENCY-1];
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // A same-cycle pop still completes; everything left behind is stale.
        if (redir) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_comb begin
        done_d = done_q;
        if (redir) done_d = 1'b0;
        else if (issue && pc_index == LAST_ADDR) done_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q       <= '0;
            pipe_addr_q <= '0;
            fifo_data_q <= '0;
            fifo_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            pipe_addr_q <= pipe_addr_d;
            fifo_data_q <= fifo_data_d;
            fifo_addr_q <= fifo_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef IFETCH_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    // Only credit starvation counts; done and redirect are intentional idles.
    always_comb begin
        stall_d = stall_q;
        if (reset && !redirect && !done_q && !credit_ok && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'h0001;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stall_q <= 16'h0000;
        else        stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC and fixed-latency memory models drive the DUT,
// each task checks one scenario against hand-computed cycle expectations.
module tb_instr_fetch;
    localparam int L = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc;
    logic        pc_enable, pc_inc_or_set, mem_rd, instr_valid;
    logic [15:0] pc_new_value, mem_addr, mem_rdata, instr_data, instr_addr;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        instr_ready = 1'b0;
`ifdef IFETCH_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int n_chk = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    instr_fetch dut (
        .clock(clock), .reset(reset), .pc_index(pc),
        .pc_enable(pc_enable), .pc_inc_or_set(pc_inc_or_set), .pc_new_value(pc_new_value),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_addr(instr_addr)
`ifdef IFETCH_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    function automatic logic [15:0] fdat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Program counter model
    always @(posedge clock or negedge reset) begin
        if (!reset) pc <= 16'h0000;
        else if (pc_enable) pc <= pc_inc_or_set ? pc_new_value : (pc == 16'hBFFF ? pc : pc + 16'h0001);
    end

    // Program memory with L-cycle read latency; not reset, so old reads still answer
    logic [L-1:0]       mv = '0;
    logic [L-1:0][15:0] ma = '0;
    always @(posedge clock) begin
        mv <= {mv[L-2:0], mem_rd};
        ma <= {ma[L-2:0], mem_addr};
    end
    assign mem_rdata = mv[L-1] ? fdat(ma[L-1]) : 16'hDEAD;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect = 1'b0;
        redirect_addr = 16'h0000;
        instr_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_chk++; if ({pc_enable, pc_inc_or_set, mem_rd} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {pc_enable, pc_inc_or_set, mem_rd}); else n_pass++;
        n_chk++; if (pc_new_value !== 16'h0) $display("FAIL reset_pc_new_value got %h want 0000", pc_new_value); else n_pass++;
        n_chk++; if (mem_addr !== 16'h0) $display("FAIL reset_mem_addr got %h want 0000", mem_addr); else n_pass++;
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid got %b want 0", instr_valid); else n_pass++;
        n_chk++; if (instr_data !== 16'h0) $display("FAIL reset_instr_data got %h want 0000", instr_data); else n_pass++;
        n_chk++; if (instr_addr !== 16'h0) $display("FAIL reset_instr_addr got %h want 0000", instr_addr); else n_pass++;
        reset = 1'b1;
        #1;
        n_chk++; if (mem_rd !== 1'b1) $display("FAIL first_issue mem_rd got %b want 1", mem_rd); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            #1;
            n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'(c)) $display("FAIL stream_issue c%0d got rd=%b addr=%h want rd=1 addr=%h", c, mem_rd, mem_addr, 16'(c)); else n_pass++;
            n_chk++; if (instr_valid !== (c >= 3)) $display("FAIL stream_valid c%0d got %b want %b", c, instr_valid, c >= 3); else n_pass++;
            if (c >= 3) begin
                n_chk++; if (instr_addr !== 16'(c - 3) || instr_data !== fdat(16'(c - 3))) $display("FAIL stream_head c%0d got %h/%h want %h/%h", c, instr_addr, instr_data, 16'(c - 3), fdat(16'(c - 3))); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic        exp_rd;
        logic [15:0] exp_ma, exp_ia;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            if (c > 0) tick();
            if (c == 10) instr_ready = 1'b1;
            #1;
            exp_rd = (c < 4) || (c >= 11);
            exp_ma = (c < 4) ? 16'(c) : 16'(c - 7);
            exp_ia = (c <= 10) ? 16'h0000 : 16'(c - 10);
            n_chk++; if (mem_rd !== exp_rd) $display("FAIL bp_mem_rd c%0d got %b want %b", c, mem_rd, exp_rd); else n_pass++;
            if (exp_rd) begin
                n_chk++; if (mem_addr !== exp_ma) $display("FAIL bp_mem_addr c%0d got %h want %h", c, mem_addr, exp_ma); else n_pass++;
            end
            n_chk++; if (instr_valid !== (c >= 3)) $display("FAIL bp_valid c%0d got %b want %b", c, instr_valid, c >= 3); else n_pass++;
            if (c >= 3) begin
                n_chk++; if (instr_addr !== exp_ia || instr_data !== fdat(exp_ia)) $display("FAIL bp_head c%0d got %h/%h want %h/%h", c, instr_addr, instr_data, exp_ia, fdat(exp_ia)); else n_pass++;
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) tick();
        redirect = 1'b1;
        redirect_addr = 16'h0100;
        #1;
        n_chk++; if ({pc_enable, pc_inc_or_set, mem_rd} !== 3'b110) $display("FAIL redir_strobes got %b want 110", {pc_enable, pc_inc_or_set, mem_rd}); else n_pass++;
        n_chk++; if (pc_new_value !== 16'h0100) $display("FAIL redir_new_value got %h want 0100", pc_new_value); else n_pass++;
        n_chk++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0000) $display("FAIL redir_pre_head got %b/%h want 1/0000", instr_valid, instr_addr); else n_pass++;
        tick();
        redirect = 1'b0;
        redirect_addr = 16'h0000;
        instr_ready = 1'b1;
        #1;
        n_chk++; if (pc_inc_or_set !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0100) $display("FAIL redir_refetch got set=%b rd=%b addr=%h want 0/1/0100", pc_inc_or_set, mem_rd, mem_addr); else n_pass++;
        for (int c = 5; c < 10; c++) begin
            if (c > 5) begin tick(); #1; end
            n_chk++; if (instr_valid !== (c >= 8)) $display("FAIL redir_valid c%0d got %b want %b", c, instr_valid, c >= 8); else n_pass++;
            if (c >= 8) begin
                n_chk++; if (instr_addr !== 16'(16'h0100 + c - 8) || instr_data !== fdat(16'(16'h0100 + c - 8))) $display("FAIL redir_head c%0d got %h/%h want %h", c, instr_addr, instr_data, 16'(16'h0100 + c - 8)); else n_pass++;
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_addr = 16'hBFFE;
        #1;
        n_chk++; if (mem_rd !== 1'b0) $display("FAIL sat_redir_rd got %b want 0", mem_rd); else n_pass++;
        for (int c = 1; c < 9; c++) begin
            tick();
            redirect = 1'b0;
            #1;
            if (c < 3) begin
                n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'(16'hBFFD + c)) $display("FAIL sat_issue c%0d got %b/%h want 1/%h", c, mem_rd, mem_addr, 16'(16'hBFFD + c)); else n_pass++;
            end else begin
                n_chk++; if (mem_rd !== 1'b0 || pc_enable !== 1'b0) $display("FAIL sat_stop c%0d got rd=%b en=%b want 0/0", c, mem_rd, pc_enable); else n_pass++;
            end
            if (c == 4 || c == 5) begin
                n_chk++; if (instr_valid !== 1'b1 || instr_addr !== 16'(16'hBFFA + c)) $display("FAIL sat_head c%0d got %b/%h want 1/%h", c, instr_valid, instr_addr, 16'(16'hBFFA + c)); else n_pass++;
            end else if (c > 5) begin
                n_chk++; if (instr_valid !== 1'b0) $display("FAIL sat_idle c%0d got %b want 0", c, instr_valid); else n_pass++;
            end
        end
        tick();
        redirect = 1'b1;
        redirect_addr = 16'h0000;
        #1;
        n_chk++; if (pc_enable !== 1'b1 || pc_inc_or_set !== 1'b1) $display("FAIL sat_resume_redir got %b%b want 11", pc_enable, pc_inc_or_set); else n_pass++;
        tick();
        redirect = 1'b0;
        #1;
        n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) $display("FAIL sat_resume got %b/%h want 1/0000", mem_rd, mem_addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) tick();
        reset = 1'b0;
        #1;
        n_chk++; if ({pc_enable, mem_rd, instr_valid} !== 3'b000) $display("FAIL mid_reset_strobes got %b want 000", {pc_enable, mem_rd, instr_valid}); else n_pass++;
        n_chk++; if (instr_data !== 16'h0 || instr_addr !== 16'h0 || mem_addr !== 16'h0) $display("FAIL mid_reset_buses got %h/%h/%h want zeros", instr_data, instr_addr, mem_addr); else n_pass++;
        @(posedge clock);
        #1;
        reset = 1'b1;
        instr_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            #1;
            n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'(c)) $display("FAIL mid_issue c%0d got %b/%h want 1/%h", c, mem_rd, mem_addr, 16'(c)); else n_pass++;
            n_chk++; if (instr_valid !== (c >= 3)) $display("FAIL mid_valid c%0d got %b want %b", c, instr_valid, c >= 3); else n_pass++;
            if (c >= 3) begin
                n_chk++; if (instr_addr !== 16'(c - 3)) $display("FAIL mid_head c%0d got %h want %h", c, instr_addr, 16'(c - 3)); else n_pass++;
            end
        end
    endtask

`ifdef IFETCH_STALL_COUNT_EN
    task automatic test_stall_count();
        do_reset();
        repeat (14) tick();
        #1;
        n_chk++; if (stall_count !== 16'd10) $display("FAIL stall_count got %0d want 10", stall_count); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_saturate();
        test_reset_mid();
`ifdef IFETCH_STALL_COUNT_EN
        test_stall_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
